// File: rtl/bp_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_update_queue                                                 |
// | Brief    : Compacting FIFO of resolved-branch updates feeding predictor    |
// |            training, plus registered GHR-restore for oldest mispredict.    |
// |            Optional statistics outputs under BP_UPDQ_STATS_EN.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bp_update_queue #(
    parameter int PC_WIDTH   = 32,
    parameter int GH_WIDTH   = 16,
    parameter int META_WIDTH = GH_WIDTH + 3,
    parameter int NUM_UPD    = 3,
    parameter int DEPTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush_i,
    input  logic [NUM_UPD-1:0]                   in_valid_i,
    input  logic [NUM_UPD-1:0][PC_WIDTH-1:0]     in_pc_i,
    input  logic [NUM_UPD-1:0][META_WIDTH-1:0]   in_meta_i,
    input  logic [NUM_UPD-1:0]                   in_mispred_i,
    input  logic [NUM_UPD-1:0][1:0]              in_cause_i,
    input  logic [NUM_UPD-1:0]                   in_actual_valid_i,
    input  logic [NUM_UPD-1:0]                   in_actual_taken_i,
    output logic                                 in_ready_o,
    output logic                                 upd_valid_o,
    input  logic                                 upd_ready_i,
    output logic [PC_WIDTH-1:0]                  upd_pc_o,
    output logic [META_WIDTH-1:0]                upd_meta_o,
    output logic                                 upd_mispred_o,
    output logic [1:0]                           upd_cause_o,
    output logic                                 upd_actual_taken_o,
    output logic                                 upd_train_o,
    output logic                                 restore_valid_o,
    output logic [GH_WIDTH-1:0]                  restore_ghr_o
`ifdef BP_UPDQ_STATS_EN
    ,
    output logic [31:0]                          stat_enq_o,
    output logic [31:0]                          stat_misp_o,
    output logic [$clog2(DEPTH+1)-1:0]           stat_hwm_o
`endif
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_ready_max = c_cnt_w'(DEPTH - NUM_UPD);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    logic [PC_WIDTH-1:0]   r_pc_mem    [DEPTH];
    logic [META_WIDTH-1:0] r_meta_mem  [DEPTH];
    logic                  r_misp_mem  [DEPTH];
    logic [1:0]            r_cause_mem [DEPTH];
    logic                  r_aval_mem  [DEPTH];
    logic                  r_taken_mem [DEPTH];

    logic [c_addr_w-1:0]   r_head;
    logic [c_addr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_restore_valid;
    logic [GH_WIDTH-1:0]   r_restore_ghr;

    logic [NUM_UPD-1:0]    w_accept;
    logic [c_addr_w-1:0]   w_wr_idx [NUM_UPD];
    logic [c_cnt_w-1:0]    w_n_in;
    logic [c_cnt_w-1:0]    w_count_next;
    logic                  w_deq;
    logic                  w_rst_hit;
    logic [GH_WIDTH-1:0]   w_rst_ghr;

    // Acceptance looks only at the registered count; a same-cycle dequeue earns no credit.
    assign in_ready_o  = (r_count <= c_ready_max);
    assign w_accept    = in_valid_i & {NUM_UPD{in_ready_o & ~flush_i}};
    assign upd_valid_o = (r_count != '0);
    assign w_deq       = upd_valid_o & upd_ready_i;

    // Accepted ports pack into consecutive slots starting at tail.
    always_comb begin
        w_n_in = '0;
        for (int i = 0; i < NUM_UPD; i++) begin
            w_wr_idx[i] = r_tail + c_addr_w'(w_n_in);
            w_n_in      = w_n_in + c_cnt_w'(w_accept[i]);
        end
    end

    // Scan high-to-low so the oldest mispredicting port wins.
    always_comb begin
        w_rst_hit = 1'b0;
        w_rst_ghr = r_restore_ghr;
        for (int i = NUM_UPD - 1; i >= 0; i--) begin
            if (w_accept[i] && in_mispred_i[i]) begin
                w_rst_hit = 1'b1;
                w_rst_ghr = {in_meta_i[i][GH_WIDTH-2:0], in_actual_taken_i[i]};
            end
        end
    end

    assign w_count_next = flush_i ? '0 : (r_count + w_n_in - c_cnt_w'(w_deq));

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UPD; i++) begin
            if (w_accept[i]) begin
                r_pc_mem[w_wr_idx[i]]    <= in_pc_i[i];
                r_meta_mem[w_wr_idx[i]]  <= in_meta_i[i];
                r_misp_mem[w_wr_idx[i]]  <= in_mispred_i[i];
                r_cause_mem[w_wr_idx[i]] <= in_cause_i[i];
                r_aval_mem[w_wr_idx[i]]  <= in_actual_valid_i[i];
                r_taken_mem[w_wr_idx[i]] <= in_actual_taken_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_restore_valid <= 1'b0;
            r_restore_ghr   <= '0;
        end else if (flush_i) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_restore_valid <= 1'b0;
        end else begin
            r_head          <= r_head + c_addr_w'(w_deq);
            r_tail          <= r_tail + c_addr_w'(w_n_in);
            r_count         <= w_count_next;
            r_restore_valid <= w_rst_hit;
            r_restore_ghr   <= w_rst_ghr;
        end
    end

    // Storage is not reset, so head fields are forced to zero while empty.
    assign upd_pc_o           = upd_valid_o ? r_pc_mem[r_head]    : '0;
    assign upd_meta_o         = upd_valid_o ? r_meta_mem[r_head]  : '0;
    assign upd_mispred_o      = upd_valid_o & r_misp_mem[r_head];
    assign upd_cause_o        = upd_valid_o ? r_cause_mem[r_head] : 2'd0;
    assign upd_actual_taken_o = upd_valid_o & r_taken_mem[r_head];
    assign upd_train_o        = upd_valid_o & r_aval_mem[r_head] & (r_cause_mem[r_head] == 2'd0);
    assign restore_valid_o    = r_restore_valid;
    assign restore_ghr_o      = r_restore_ghr;

`ifdef BP_UPDQ_STATS_EN
    logic [31:0]        r_stat_enq;
    logic [31:0]        r_stat_misp;
    logic [c_cnt_w-1:0] r_stat_hwm;
    logic [c_cnt_w-1:0] w_n_misp;

    always_comb begin
        w_n_misp = '0;
        for (int i = 0; i < NUM_UPD; i++) begin
            w_n_misp = w_n_misp + c_cnt_w'(w_accept[i] & in_mispred_i[i]);
        end
    end

    // Statistics survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_enq  <= '0;
            r_stat_misp <= '0;
            r_stat_hwm  <= '0;
        end else begin
            r_stat_enq  <= r_stat_enq + 32'(w_n_in);
            r_stat_misp <= r_stat_misp + 32'(w_n_misp);
            if (w_count_next > r_stat_hwm) begin
                r_stat_hwm <= w_count_next;
            end
        end
    end

    assign stat_enq_o  = r_stat_enq;
    assign stat_misp_o = r_stat_misp;
    assign stat_hwm_o  = r_stat_hwm;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= c_depth_cnt);

endmodule
`default_nettype wire
